// File: rtl/trap_ctrl_unit.sv
// trap_ctrl_unit: latches edge-triggered sources, masks with mie, arbitrates (index 0 wins) and
// sequences ENTER -> HANDLER -> EXIT, redirecting the PC to a vectored handler and back to mepc.
// Redirect and IF/ID, ID/EX clears are held FLUSH_CYCLES on entry and on exit; no trap nesting.
module trap_ctrl_unit #(
  parameter int unsigned NUM_SRC      = 8,
  parameter int unsigned VEC_STRIDE   = 8,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] MTVEC_RST    = 32'hF000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        if_pc,
  input  logic [31:0]        id_pc,
  input  logic               csr_wen,
  input  logic [11:0]        csr_wadd,
  input  logic [31:0]        csr_din,
  input  logic [11:0]        csr_radd,
  output logic [31:0]        csr_dout,
  output logic               pc_wen,
  output logic               npc_mux_sel,
  output logic [31:0]        pc_dout,
  output logic               if_id_clear,
  output logic               id_ex_clear,
  output logic               trap_active
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [11:0] ADDR_MIE    = 12'h304;
  localparam logic [11:0] ADDR_MIP    = 12'h344;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MIPD   = 12'h100;

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, EXIT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               redirect_q;
  logic               active_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] mie_q;
  logic [31:0]        mcause_q;
  logic [31:0]        mepc_q;
  logic [31:0]        mtvec_q;

  logic [NUM_SRC-1:0] req;
  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic               take_trap;
  logic               wr_mie, wr_mip, wr_mcause, wr_mepc, wr_mtvec, mipd_done;

  // The return address comes from the ID stage, so the IF-stage PC is not needed here.
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;

  assign req       = pending_q & mie_q;
  assign any_req   = |req;
  assign take_trap = (state_q == IDLE) && any_req;

  assign wr_mie    = csr_wen && (csr_wadd == ADDR_MIE);
  assign wr_mip    = csr_wen && (csr_wadd == ADDR_MIP);
  assign wr_mcause = csr_wen && (csr_wadd == ADDR_MCAUSE);
  assign wr_mepc   = csr_wen && (csr_wadd == ADDR_MEPC);
  assign wr_mtvec  = csr_wen && (csr_wadd == ADDR_MTVEC);
  assign mipd_done = csr_wen && (csr_wadd == ADDR_MIPD) && csr_din[0];

  // Priority pick: scanning downward leaves the lowest set index as the winner.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
  end

  // Pending next-state: software clear and arbitration clear first, then new edges win.
  always_comb begin
    pending_d = pending_q;
    if (wr_mip)    pending_d = pending_d & ~csr_din[NUM_SRC-1:0];
    if (take_trap) pending_d = pending_d & ~(NUM_SRC'(1) << win_idx);
    pending_d = pending_d | (irq_src & ~prev_q);
  end

  // CSR storage, edge history and trap-entry capture of mcause/mepc (entry beats software writes).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q    <= '0;
      pending_q <= '0;
      mie_q     <= '0;
      mcause_q  <= '0;
      mepc_q    <= '0;
      mtvec_q   <= MTVEC_RST;
    end else begin
      prev_q    <= irq_src;
      pending_q <= pending_d;
      if (wr_mie)   mie_q   <= csr_din[NUM_SRC-1:0];
      if (wr_mtvec) mtvec_q <= csr_din;
      if (take_trap) begin
        mcause_q <= 32'(win_idx);
        mepc_q   <= id_pc;
      end else begin
        if (wr_mcause) mcause_q <= csr_din;
        if (wr_mepc)   mepc_q   <= csr_din;
      end
    end
  end

  // Trap sequencer with registered redirect/active flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      redirect_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            idx_q      <= win_idx;
            cnt_q      <= CNT_INIT;
            redirect_q <= 1'b1;
            active_q   <= 1'b1;
            state_q    <= ENTER;
          end
        end
        ENTER: begin
          if (cnt_q == '0) begin
            redirect_q <= 1'b0;
            state_q    <= HANDLER;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HANDLER: begin
          if (mipd_done) begin
            cnt_q      <= CNT_INIT;
            redirect_q <= 1'b1;
            state_q    <= EXIT;
          end
        end
        EXIT: begin
          if (cnt_q == '0) begin
            redirect_q <= 1'b0;
            active_q   <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          redirect_q <= 1'b0;
          active_q   <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign pc_wen      = redirect_q;
  assign npc_mux_sel = redirect_q;
  assign if_id_clear = redirect_q;
  assign id_ex_clear = redirect_q;
  assign trap_active = active_q;

  // Redirect target tracks live mtvec/mepc so software updates show up on the next cycle.
  always_comb begin
    pc_dout = '0;
    if (redirect_q) begin
      if (state_q == ENTER) pc_dout = mtvec_q + 32'(idx_q) * 32'(VEC_STRIDE);
      else                  pc_dout = mepc_q;
    end
  end

  // CSR read mux; unmapped addresses and mipd read as zero.
  always_comb begin
    csr_dout = '0;
    case (csr_radd)
      ADDR_MIE:    csr_dout = 32'(mie_q);
      ADDR_MIP:    csr_dout = 32'(pending_q);
      ADDR_MCAUSE: csr_dout = mcause_q;
      ADDR_MEPC:   csr_dout = mepc_q;
      ADDR_MTVEC:  csr_dout = mtvec_q;
      default:     csr_dout = '0;
    endcase
  end

endmodule
